axi_rom_responder: RTL and testbench

- AXI3 slave that answers the instruction-side AXI master (icache line refills) from a word-addressed synchronous ROM/BRAM.
- Read channels support FIXED, INCR and WRAP bursts of 1–16 beats.
- Write channels are accepted and completed with SLVERR, because the space is read-only.
- Sits at the far end of the instr AXI bus: in the SoC as the boot-ROM slave, and on the bench as the memory model.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_addr.sv | 28 ++
 rtl/axi_rom_responder.sv | 190 +++++++++++++++++++
 tb/tb_axi_rom_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// AXI encodings and state types shared by AXI slaves on the instr/data buses.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FETCH, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    // Read burst context held for the life of a burst; addr is the current beat address.
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
    } ar_req_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI3 next-beat address for 32-bit beats (FIXED / INCR / WRAP).
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] cur,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next
);

    logic [31:0] incr;
    logic [31:0] mask;
    logic        wrap_ok;

    assign incr    = cur + 32'd4;
    // For legal wrap lengths (2^n-1) this is exactly span-1 with span=(len+1)*4.
    assign mask    = {26'd0, len, 2'b11};
    assign wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);

    always_comb begin
        next = incr;
        if (burst == BURST_FIXED)
            next = cur;
        else if (burst == BURST_WRAP && wrap_ok)
            next = (cur & ~mask) | (incr & mask);
    end

endmodule

// File: rtl/axi_rom_responder.sv
// AXI3 read-only slave serving bursts from a word-addressed synchronous ROM;
// writes are drained and answered with SLVERR.
module axi_rom_responder
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h1fc0_0000,
    parameter int          MEM_AW   = 12,
    parameter int          READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam logic [32:0] TOP = {1'b0, BASE} + (33'd4 << MEM_AW);

    rd_state_t   rs, rs_nxt;
    wr_state_t   ws, ws_nxt;
    ar_req_t     ar_q;
    logic [3:0]  beat_q;
    logic [3:0]  lat_q;
    logic [3:0]  awid_q;
    logic [31:0] next_addr;
    logic [31:0] off;
    logic [1:0]  resp;
    logic        last;

    axi_burst_addr u_addr (
        .cur   (ar_q.addr),
        .len   (ar_q.len),
        .burst (ar_q.burst),
        .next  (next_addr)
    );

    assign off  = ar_q.addr - BASE;
    assign last = (beat_q == ar_q.len);

    // Response is re-evaluated every beat so an INCR burst can walk off the window.
    always_comb begin
        if ({1'b0, ar_q.addr} < {1'b0, BASE} || {1'b0, ar_q.addr} >= TOP)
            resp = RESP_DECERR;
        else if (ar_q.burst == 2'b11)
            resp = RESP_SLVERR;
        else
            resp = RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs     <= R_IDLE;
            ar_q   <= '0;
            beat_q <= '0;
            lat_q  <= '0;
        end else begin
            rs <= rs_nxt;
            case (rs)
                R_IDLE: if (arvalid) begin
                    ar_q   <= '{arid, araddr, arlen, arburst};
                    beat_q <= '0;
                    lat_q  <= '0;
                end
                R_WAIT: lat_q <= lat_q + 4'd1;
                R_DATA: if (rready && !last) begin
                    beat_q    <= beat_q + 4'd1;
                    ar_q.addr <= next_addr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rs_nxt   = rs;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rid      = '0;
        rdata    = '0;
        rresp    = '0;
        rlast    = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        case (rs)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) rs_nxt = (READ_LAT > 0) ? R_WAIT : R_FETCH;
            end
            R_WAIT: if (lat_q == 4'(READ_LAT - 1)) rs_nxt = R_FETCH;
            R_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = off[MEM_AW+1:2];
                rs_nxt   = R_DATA;
            end
            R_DATA: begin
                // mem_en stays low here, so mem_rdata holds through backpressure.
                rvalid = 1'b1;
                rid    = ar_q.id;
                rresp  = resp;
                rlast  = last;
                rdata  = (resp == RESP_OKAY) ? mem_rdata : '0;
                if (rready) rs_nxt = last ? R_IDLE : R_FETCH;
            end
            default: rs_nxt = R_IDLE;
        endcase
        if (rst) begin
            arready  = 1'b0;
            rvalid   = 1'b0;
            rid      = '0;
            rdata    = '0;
            rresp    = '0;
            rlast    = 1'b0;
            mem_en   = 1'b0;
            mem_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws     <= W_IDLE;
            awid_q <= '0;
        end else begin
            ws <= ws_nxt;
            if (ws == W_IDLE && awvalid) awid_q <= awid;
        end
    end

    always_comb begin
        ws_nxt  = ws;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = '0;
        case (ws)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) ws_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) ws_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = awid_q;
                bresp  = RESP_SLVERR;
                if (bready) ws_nxt = W_IDLE;
            end
            default: ws_nxt = W_IDLE;
        endcase
        if (rst) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bid     = '0;
            bresp   = '0;
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{arsize, awaddr, wid, wdata, off[31:MEM_AW+2], off[1:0]};

endmodule

// File: tb/tb_axi_rom_responder.sv
// Randomized scoreboard bench for axi_rom_responder with an address-list reference model.
module tb_axi_rom_responder;

    localparam logic [31:0] BASE   = 32'h1fc0_0000;
    localparam int          MEM_AW = 12;
    localparam int          DEPTH  = 1 << MEM_AW;
    localparam logic [31:0] TOPA   = BASE + 32'(4 * DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        arid = '0;
    logic [31:0]       araddr = '0;
    logic [3:0]        arlen = '0;
    logic [2:0]        arsize = 3'b010;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [3:0]        awid = '0;
    logic [31:0]       awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [3:0]        wid = '0;
    logic [31:0]       wdata = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;

    always #5 clk = ~clk;

    axi_rom_responder #(.BASE(BASE), .MEM_AW(MEM_AW), .READ_LAT(0)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    logic [31:0] rom [DEPTH];
    always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [3:0] bq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int stall_until = 0;
    int stall_seen = 0;
    bit rr_rand = 0;
    bit bb_rand = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: enumerate every beat address of the burst directly from the AXI rules.
    task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst);
        longint la, lb, lt, span, lo, a;
        bit     wrap;
        rbeat_t b;
        la   = longint'(addr);
        lb   = longint'(BASE);
        lt   = longint'(TOPA);
        wrap = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
        span = (len + 1) * 4;
        lo   = la - (la % span);
        for (int i = 0; i <= len; i++) begin
            if (burst == 2'b00)  a = la;
            else if (wrap)       a = lo + ((la - lo + 4 * i) % span);
            else                 a = la + 4 * i;
            b.id   = id;
            b.last = (i == len);
            if (a < lb || a >= lt) b.resp = 2'b11;
            else if (burst == 2'b11) b.resp = 2'b10;
            else b.resp = 2'b00;
            b.data = (b.resp == 2'b00) ? rom[int'((a - lb) >> 2)] : 32'd0;
            rq.push_back(b);
        end
    endtask

    // Ready drivers: random or held high, with a test-requested stall window.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (cyc < stall_until) rready = 1'b0;
        else if (rr_rand)      rready = ($urandom_range(0, 2) != 0);
        else                   rready = 1'b1;
        bready = bb_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
    end

    // R monitor: pops on each handshake and checks stability while stalled.
    logic [31:0] h_data;
    logic [6:0]  h_ctl;
    bit          held = 0;
    initial forever begin
        @(negedge clk);
        if (rst) held = 0;
        else begin
            if (held && !rvalid) chk("r_dropped_beat", 32'(rvalid), 32'd1);
            if (rvalid) begin
                chk("r_mem_en_quiet", 32'(mem_en), 32'd0);
                if (held) begin
                    chk("r_hold_data", rdata, h_data);
                    chk("r_hold_ctl", 32'({rid, rresp, rlast}), 32'(h_ctl));
                    stall_seen++;
                end
                if (rready) begin
                    held = 0;
                    if (rq.size() == 0) chk("r_unexpected_beat", 32'(rq.size()), 32'd1);
                    else begin
                        rbeat_t b;
                        b = rq.pop_front();
                        chk("r_id", 32'(rid), 32'(b.id));
                        chk("r_data", rdata, b.data);
                        chk("r_resp", 32'(rresp), 32'(b.resp));
                        chk("r_last", 32'(rlast), 32'(b.last));
                    end
                end else begin
                    held   = 1;
                    h_data = rdata;
                    h_ctl  = {rid, rresp, rlast};
                end
            end else held = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 32'(bq.size()), 32'd1);
            else begin
                chk("b_id", 32'(bid), 32'(bq.pop_front()));
                chk("b_resp", 32'(bresp), 32'd2);
            end
        end
    end

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit chk_lat);
        int n = 0;
        @(posedge clk); #1;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst;
        arsize = 3'($urandom);
        do begin @(negedge clk); n++; end while (!arready && n < 400);
        if (!arready) begin
            chk("ar_timeout", 32'(arready), 32'd1);
            arvalid = 1'b0;
            return;
        end
        push_read(id, addr, int'(len), burst);
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (chk_lat) begin
            chk("lat_T1_rvalid", 32'(rvalid), 32'd0);
            @(posedge clk); #1;
            chk("lat_T2_rvalid", 32'(rvalid), 32'd1);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input int nb, input bit early);
        int n = 0;
        @(posedge clk); #1;
        if (early) begin
            wvalid = 1'b1; wlast = 1'b0;
            repeat (2) begin @(negedge clk); chk("wready_before_aw", 32'(wready), 32'd0); end
            @(posedge clk); #1;
        end
        awvalid = 1'b1; awid = id; awaddr = $urandom;
        do begin @(negedge clk); n++; end while (!awready && n < 400);
        if (!awready) begin chk("aw_timeout", 32'(awready), 32'd1); awvalid = 1'b0; return; end
        bq.push_back(id);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wvalid = 1'b1; wlast = (i == nb - 1); wdata = $urandom; wid = 4'($urandom);
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 400);
            if (!wready) begin chk("w_timeout", 32'(wready), 32'd1); break; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin @(posedge clk); n++; end
        if (rq.size() != 0 || bq.size() != 0) begin
            chk("drain_timeout", 32'(rq.size() + bq.size()), 32'd0);
            rq.delete(); bq.delete();
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdata"}, rdata, 32'd0);
        chk({nm, "_ctl"}, 32'({arready, rid, rresp, rlast, rvalid, awready, wready,
                               bid, bresp, bvalid, mem_en, mem_addr}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        rom[0] = 32'h3c08bfc0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset_arready", 32'(arready), 32'd1);
        chk("reset_awready", 32'(awready), 32'd1);

        // Single beat with first-beat latency and return to idle.
        send_ar(4'h3, BASE, 4'd0, 2'b01, 1'b1);
        @(posedge clk); #1;
        chk("single_arready_again", 32'(arready), 32'd1);
        chk("single_rvalid_low", 32'(rvalid), 32'd0);
        drain();

        send_ar(4'h1, BASE + 32'h14, 4'd7, 2'b10, 1'b0);
        drain();

        // Stall beat 2 of INCR4 for three cycles.
        begin
            int s0, n;
            s0 = stall_seen;
            n  = 0;
            send_ar(4'h2, BASE + 32'h100, 4'd3, 2'b01, 1'b0);
            do begin @(posedge clk); #2; n++; end while (rq.size() != 3 && n < 100);
            stall_until = cyc + 4;
            drain();
            chk("bp_stall_cycles", 32'(stall_seen - s0), 32'd3);
        end

        send_ar(4'h6, TOPA - 32'd4, 4'd1, 2'b01, 1'b0);
        drain();

        do_write(4'h5, 2, 1'b1);
        drain();
        @(posedge clk); #1;
        chk("write_awready_again", 32'(awready), 32'd1);

        // Reset at beat 3 of INCR8, then a fresh INCR2.
        begin
            int n = 0;
            send_ar(4'h7, BASE + 32'h200, 4'd7, 2'b01, 1'b0);
            do begin @(posedge clk); #2; n++; end while (rq.size() != 5 && n < 100);
            rst = 1'b1;
            @(posedge clk); #1;
            chk_zero("rst_mid");
            rq.delete();
            rst = 1'b0;
            @(negedge clk);
            chk("rst_mid_arready", 32'(arready), 32'd1);
            send_ar(4'h8, BASE + 32'h40, 4'd1, 2'b01, 1'b0);
            drain();
        end

        fork
            send_ar(4'h9, BASE + 32'h80, 4'd3, 2'b10, 1'b0);
            do_write(4'ha, 1, 1'b0);
        join
        drain();

        rr_rand = 1; bb_rand = 1;
        for (int it = 0; it < 40; it++) begin
            logic [1:0]  bu;
            logic [3:0]  ln;
            logic [31:0] ad;
            int          sel;
            bu  = 2'($urandom);
            ln  = 4'($urandom);
            sel = (bu == 2'b11) ? $urandom_range(0, 6) : $urandom_range(0, 9);
            if (sel < 7)       ad = BASE + 32'(4 * $urandom_range(0, DEPTH - 17));
            else if (sel == 7) ad = TOPA - 32'(4 * $urandom_range(1, 8));
            else if (sel == 8) ad = BASE - 32'(4 * $urandom_range(1, 4));
            else               ad = TOPA + 32'(4 * $urandom_range(0, 64));
            if ($urandom_range(0, 3) == 0)
                fork
                    send_ar(4'($urandom), ad, ln, bu, 1'b0);
                    do_write(4'($urandom), $urandom_range(1, 4), 1'($urandom));
                join
            else
                send_ar(4'($urandom), ad, ln, bu, 1'b0);
        end
        drain();
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
